// File: rtl/freqgen_if.sv
// Config/control handshake and sample-stream bundle for the square-wave generator.
// Pure wiring, no latency.
// cfg_valid/cfg_ready handshake; the sample stream itself is never backpressured.
interface freqgen_if;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [31:0] cfg_freq;
    logic [31:0] cfg_cycles;
    logic        start;
    logic        stop;
    logic [7:0]  data_out;
    logic        busy;
    logic        done;
    logic [31:0] period_cnt;

    // Controller / stimulus side
    modport master (
        output cfg_valid, cfg_freq, cfg_cycles, start, stop,
        input  cfg_ready, data_out, busy, done, period_cnt
    );

    // Generator side
    modport slave (
        input  cfg_valid, cfg_freq, cfg_cycles, start, stop,
        output cfg_ready, data_out, busy, done, period_cnt
    );
endinterface

// File: rtl/freqgen.sv
// Square-wave sample generator: modulo-CLK_HZ phase accumulator gives exactly freq rising edges per CLK_HZ clocks.
// First HI sample one cycle after start is sampled; all outputs registered.
// Config accepted only in IDLE (cfg_ready); start ignored while running; stop aborts on the next edge.
module freqgen #(
    parameter int unsigned CLK_HZ  = 50_000_000,
    parameter logic [7:0]  HI_CODE = 8'd192,
    parameter logic [7:0]  LO_CODE = 8'd64
) (
    input  logic      aclk,
    input  logic      rstn,
    freqgen_if.slave  bus
);
    localparam logic [32:0] MOD  = 33'(CLK_HZ);
    localparam logic [31:0] HALF = 32'(CLK_HZ / 2);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state;
    logic [31:0] acc;
    logic [31:0] freq_q;
    logic [31:0] cycles_q;
    logic [31:0] period_cnt;
    logic [7:0]  data_out;
    logic        busy;
    logic        done;

    logic [32:0] sum;
    logic        wrap;
    logic [31:0] acc_next;
    logic [31:0] period_inc;
    logic        last_period;
    logic [31:0] freq_clamped;

    assign bus.cfg_ready  = (state == IDLE);
    assign bus.data_out   = data_out;
    assign bus.busy       = busy;
    assign bus.done       = done;
    assign bus.period_cnt = period_cnt;

    // Next phase: 33-bit sum so acc + freq never overflows before the modulus test
    always_comb begin
        sum          = {1'b0, acc} + {1'b0, freq_q};
        wrap         = (sum >= MOD);
        acc_next     = wrap ? 32'(sum - MOD) : sum[31:0];
        period_inc   = period_cnt + 32'd1;
        last_period  = wrap && (cycles_q != 32'd0) && (period_inc == cycles_q);
        freq_clamped = (bus.cfg_freq > HALF) ? HALF : bus.cfg_freq;
    end

    // Control FSM, config latch, phase accumulator and registered outputs
    always_ff @(posedge aclk) begin
        if (!rstn) begin
            state      <= IDLE;
            acc        <= 32'd0;
            freq_q     <= 32'd0;
            cycles_q   <= 32'd0;
            data_out   <= LO_CODE;
            busy       <= 1'b0;
            done       <= 1'b0;
            period_cnt <= 32'd0;
        end else begin
            done <= 1'b0;

            // The start decision below reads freq_q before this update lands,
            // so a same-cycle config + start runs with the old frequency.
            if (bus.cfg_valid && (state == IDLE)) begin
                freq_q   <= freq_clamped;
                cycles_q <= bus.cfg_cycles;
            end

            case (state)
                IDLE: begin
                    if (bus.start && !bus.stop && (freq_q != 32'd0)) begin
                        state      <= RUN;
                        busy       <= 1'b1;
                        acc        <= 32'd0;
                        period_cnt <= 32'd0;
                        data_out   <= HI_CODE;
                    end
                end
                RUN: begin
                    if (bus.stop) begin
                        // Abort wins over a coincident final wrap: no count, no done.
                        state    <= IDLE;
                        busy     <= 1'b0;
                        data_out <= LO_CODE;
                    end else begin
                        acc <= acc_next;
                        if (wrap) begin
                            period_cnt <= period_inc;
                        end
                        if (last_period) begin
                            // Suppress the HI of the would-be next period.
                            state    <= IDLE;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            data_out <= LO_CODE;
                        end else begin
                            data_out <= (acc_next < HALF) ? HI_CODE : LO_CODE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_freqgen.sv
// Scoreboard bench for freqgen: stimulus queues expected samples per cycle, monitor checks at negedge.
module tb_freqgen;
    localparam int unsigned CLK_HZ = 1000;
    localparam logic [7:0]  HI     = 8'd192;
    localparam logic [7:0]  LO     = 8'd64;

    logic aclk = 1'b0;
    logic rstn = 1'b0;

    freqgen_if bus ();

    freqgen #(
        .CLK_HZ (CLK_HZ),
        .HI_CODE(HI),
        .LO_CODE(LO)
    ) dut (
        .aclk(aclk),
        .rstn(rstn),
        .bus (bus)
    );

    always #5 aclk = ~aclk;

    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    typedef struct {
        int          kind;   // 0: sample check, 1: rising-edge count over a window
        int          cyc;
        int          from;
        logic [7:0]  d;
        bit          b;
        bit          dn;
        logic [31:0] pc;
        bit          cr;
        int          edges;
    } exp_t;

    exp_t  sb_q[$];
    string name_q[$];

    int   tests_run    = 0;
    int   tests_failed = 0;
    int   edges        = 0;
    logic prev_hi      = 1'b0;
    int   cum [0:8191];

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic push_s(input string nm, input int c, input logic [7:0] d, input bit b,
                          input bit dn, input logic [31:0] pc, input bit cr);
        exp_t x;
        x.kind = 0; x.cyc = c; x.from = 0; x.d = d; x.b = b; x.dn = dn;
        x.pc = pc; x.cr = cr; x.edges = 0;
        sb_q.push_back(x);
        name_q.push_back(nm);
    endtask

    task automatic push_e(input string nm, input int from, input int to, input int n);
        exp_t x;
        x.kind = 1; x.cyc = to; x.from = from; x.d = 8'd0; x.b = 1'b0; x.dn = 1'b0;
        x.pc = 32'd0; x.cr = 1'b0; x.edges = n;
        sb_q.push_back(x);
        name_q.push_back(nm);
    endtask

    task automatic cfg(input logic [31:0] f, input logic [31:0] n);
        bus.cfg_valid  = 1'b1;
        bus.cfg_freq   = f;
        bus.cfg_cycles = n;
        tick();
        bus.cfg_valid  = 1'b0;
    endtask

    task automatic do_start(output int e);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        e = cyc;
    endtask

    task automatic do_stop(output int s);
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        s = cyc;
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) tick();
    endtask

    // Monitor: track rising edges of the thresholded stream and retire due expectations
    always @(negedge aclk) begin
        exp_t  x;
        string nm;
        int    got;
        logic  hi;
        hi = (bus.data_out >= 8'h80);
        if (hi === 1'b1 && prev_hi !== 1'b1) edges = edges + 1;
        prev_hi = hi;
        if (cyc < 8192) cum[cyc] = edges;
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            x  = sb_q.pop_front();
            nm = name_q.pop_front();
            tests_run = tests_run + 1;
            if (x.cyc < cyc) begin
                tests_failed = tests_failed + 1;
                $display("FAIL %s: check for cycle %0d missed (now cycle %0d)", nm, x.cyc, cyc);
            end else if (x.kind == 0) begin
                if (bus.data_out !== x.d || bus.busy !== x.b || bus.done !== x.dn ||
                    bus.period_cnt !== x.pc || bus.cfg_ready !== x.cr) begin
                    tests_failed = tests_failed + 1;
                    $display("FAIL %s @cyc %0d: got data=%0d busy=%0b done=%0b pcnt=%0d rdy=%0b, want data=%0d busy=%0b done=%0b pcnt=%0d rdy=%0b",
                             nm, cyc, bus.data_out, bus.busy, bus.done, bus.period_cnt, bus.cfg_ready,
                             x.d, x.b, x.dn, x.pc, x.cr);
                end
            end else begin
                got = cum[x.cyc] - cum[x.from - 1];
                if (got != x.edges) begin
                    tests_failed = tests_failed + 1;
                    $display("FAIL %s: got %0d rising edges, want %0d", nm, got, x.edges);
                end
            end
        end
    end

    initial begin
        int e, s, r, guard;
        bus.cfg_valid  = 1'b0;
        bus.cfg_freq   = 32'd0;
        bus.cfg_cycles = 32'd0;
        bus.start      = 1'b0;
        bus.stop       = 1'b0;

        // Reset held for three edges
        rstn = 1'b0;
        tick(); tick(); tick();
        push_s("reset", cyc, LO, 0, 0, 0, 1);
        rstn = 1'b1;
        push_s("idle_after_reset", cyc + 1, LO, 0, 0, 0, 1);
        tick(); tick();

        // Continuous 100 Hz: 5 HI / 5 LO, ten periods in 100 clocks
        cfg(100, 0);
        do_start(e);
        for (int k = 0; k <= 100; k++)
            push_s("cont", e + k, ((k % 10) < 5) ? HI : LO, 1, 0, k / 10, 0);
        wait_to(e + 100);
        do_stop(s);
        push_s("cont_stop", s, LO, 0, 0, (s - e - 1) / 10, 1);

        // Exact edge counts over one CLK_HZ window from entry
        cfg(3, 0);
        do_start(e);
        push_e("edges_f3", e, e + 999, 3);
        wait_to(e + 999);
        do_stop(s);
        push_s("f3_stop", s, LO, 0, 0, 2, 1);

        cfg(7, 0);
        do_start(e);
        push_e("edges_f7", e, e + 999, 7);
        wait_to(e + 999);
        do_stop(s);
        push_s("f7_stop", s, LO, 0, 0, 6, 1);

        // Burst of four 250 Hz periods, run twice with the same latched config
        cfg(250, 4);
        for (int run = 0; run < 2; run++) begin
            do_start(e);
            for (int k = 0; k < 16; k++)
                push_s("burst", e + k, ((k % 4) < 2) ? HI : LO, 1, 0, k / 4, 0);
            push_s("burst_done", e + 16, LO, 0, 1, 4, 1);
            push_s("burst_after", e + 17, LO, 0, 0, 4, 1);
            wait_to(e + 18);
        end

        // Nyquist clamp: 700 behaves as 500, strict alternation
        cfg(700, 0);
        do_start(e);
        for (int k = 0; k < 10; k++)
            push_s("clamp", e + k, ((k % 2) == 0) ? HI : LO, 1, 0, k / 2, 0);
        wait_to(e + 9);
        do_stop(s);
        push_s("clamp_stop", s, LO, 0, 0, 4, 1);

        // start with zero frequency is ignored
        cfg(0, 0);
        do_start(e);
        push_s("start_f0_ignored", e, LO, 0, 0, 4, 1);

        // Config and start together: start sees the old (zero) frequency
        bus.cfg_valid  = 1'b1;
        bus.cfg_freq   = 100;
        bus.cfg_cycles = 0;
        bus.start      = 1'b1;
        tick();
        bus.cfg_valid  = 1'b0;
        bus.start      = 1'b0;
        push_s("cfg_start_same_cycle", cyc, LO, 0, 0, 4, 1);
        do_start(e);
        push_s("new_cfg_applies", e, HI, 1, 0, 0, 0);
        push_s("new_cfg_lo_half", e + 5, LO, 1, 0, 0, 0);
        wait_to(e + 5);
        do_stop(s);
        push_s("new_cfg_stop", s, LO, 0, 0, 0, 1);

        // start and stop together in IDLE
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        push_s("start_stop_idle", cyc, LO, 0, 0, 0, 1);
        push_s("start_stop_idle2", cyc + 1, LO, 0, 0, 0, 1);
        tick();

        // Abort a 50-period burst once three periods have completed
        cfg(100, 50);
        do_start(e);
        for (int k = 0; k <= 30; k++)
            push_s("abort_run", e + k, ((k % 10) < 5) ? HI : LO, 1, 0, k / 10, 0);
        wait_to(e + 30);
        do_stop(s);
        push_s("abort", s, LO, 0, 0, 3, 1);
        push_s("abort_hold", s + 1, LO, 0, 0, 3, 1);
        tick();

        // Reset in the middle of a run
        do_start(e);
        for (int k = 0; k <= 11; k++)
            push_s("pre_reset_run", e + k, ((k % 10) < 5) ? HI : LO, 1, 0, k / 10, 0);
        wait_to(e + 11);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        r = cyc;
        push_s("reset_midrun", r, LO, 0, 0, 0, 1);
        do_start(e);
        push_s("start_after_reset_f0", e, LO, 0, 0, 0, 1);

        // Drain the scoreboard with a bounded wait
        guard = 0;
        while (sb_q.size() > 0 && guard < 200) begin
            tick();
            guard++;
        end
        if (sb_q.size() > 0) begin
            tests_run    = tests_run + 1;
            tests_failed = tests_failed + 1;
            $display("FAIL drain: %0d expectations left unchecked, want 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
